// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/miss/over flow, paddle contact, score and lives.
// Drives endgame/animate levels and serve/bounce pulses for the ball and paddle.
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 120,
  parameter int SCORE_W      = 10,
  parameter int D_HEIGHT     = 480
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_btn_active,
  input  logic [11:0]        i_ball_x1,
  input  logic [11:0]        i_ball_x2,
  input  logic [11:0]        i_ball_y2,
  input  logic [11:0]        i_pad_x1,
  input  logic [11:0]        i_pad_x2,
  input  logic [11:0]        i_pad_y1,
  output logic               o_endgame,
  output logic               o_animate,
  output logic               o_serve,
  output logic               o_bounce,
  output logic [SCORE_W-1:0] o_score,
  output logic [3:0]         o_lives,
  output logic [2:0]         o_state
);

  localparam int MAXF = (SERVE_FRAMES > OVER_FRAMES) ?
                        SERVE_FRAMES : OVER_FRAMES;
  localparam int TW = $clog2(MAXF + 1);
  localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_FRAMES - 1);
  localparam logic [TW-1:0] OVER_LAST  = TW'(OVER_FRAMES - 1);
  localparam logic [11:0] MISS_LINE = 12'(D_HEIGHT - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                lock_q, lock_d;
  logic                btn_q;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [3:0]          lives_q, lives_d;
  logic                serve_q, serve_d;
  logic                bounce_q, bounce_d;
  logic                endgame_q, animate_q;
  logic                start;
  logic                hit;
  logic                miss;

  assign start = i_btn_active & ~btn_q;

  assign hit = (i_ball_y2 >= i_pad_y1) &
               (i_ball_x2 >= i_pad_x1) &
               (i_ball_x1 <= i_pad_x2) & ~lock_q;

  assign miss = (i_ball_y2 >= MISS_LINE) & ~hit;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    lock_d   = lock_q;
    score_d  = score_q;
    lives_d  = lives_q;
    serve_d  = 1'b0;
    bounce_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lives_d = 4'(LIVES);
          score_d = '0;
          timer_d = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (i_ani_stb) begin
          if (timer_q == SERVE_LAST) begin
            state_d = PLAY;
            serve_d = 1'b1;
            timer_d = '0;
            lock_d  = 1'b0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      PLAY: begin
        if (i_ani_stb) begin
          if (i_ball_y2 < i_pad_y1) lock_d = 1'b0;
          // hit has priority; miss already excludes it
          if (hit) begin
            bounce_d = 1'b1;
            lock_d   = 1'b1;
            if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
          end else if (miss) begin
            if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        if (i_ani_stb) begin
          timer_d = '0;
          state_d = (lives_q == 4'd0) ? OVER : SERVE;
        end
      end
      OVER: begin
        if (i_ani_stb) begin
          if (timer_q == OVER_LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      lock_q    <= 1'b0;
      btn_q     <= 1'b0;
      score_q   <= '0;
      lives_q   <= 4'(LIVES);
      serve_q   <= 1'b0;
      bounce_q  <= 1'b0;
      endgame_q <= 1'b1;
      animate_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lock_q    <= lock_d;
      btn_q     <= i_btn_active;
      score_q   <= score_d;
      lives_q   <= lives_d;
      serve_q   <= serve_d;
      bounce_q  <= bounce_d;
      endgame_q <= (state_d == IDLE) | (state_d == MISS) |
                   (state_d == OVER);
      animate_q <= (state_d == PLAY);
    end
  end

  assign o_endgame = endgame_q;
  assign o_animate = animate_q;
  assign o_serve   = serve_q;
  assign o_bounce  = bounce_q;
  assign o_score   = score_q;
  assign o_lives   = lives_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game flow with a pulse scoreboard.
// Serve/bounce pulses are checked against queued expectations.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        btn = 1'b0;
  logic [11:0] bx1 = 12'd300, bx2 = 12'd310, by2 = 12'd100;
  logic [11:0] px1 = 12'd290, px2 = 12'd350, py1 = 12'd475;
  logic        endgame, animate, serve, bounce;
  logic [9:0]  score;
  logic [3:0]  lives;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit kind;
    int score;
    int lives;
  } ev_t;

  ev_t exp_q[$];

  pong_game_ctrl #(
    .LIVES(2), .SERVE_FRAMES(4), .OVER_FRAMES(6),
    .SCORE_W(10), .D_HEIGHT(480)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(stb),
    .i_btn_active(btn),
    .i_ball_x1(bx1), .i_ball_x2(bx2), .i_ball_y2(by2),
    .i_pad_x1(px1), .i_pad_x2(px2), .i_pad_y1(py1),
    .o_endgame(endgame), .o_animate(animate),
    .o_serve(serve), .o_bounce(bounce),
    .o_score(score), .o_lives(lives), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic push(input bit k, input int s, input int l);
    ev_t e;
    e.kind = k;
    e.score = s;
    e.lives = l;
    exp_q.push_back(e);
  endtask

  // scoreboard monitor: one expectation per observed pulse
  always @(negedge clk) begin
    if (rst_n && (serve || bounce)) begin
      ev_t e;
      chk("pulse_excl", int'(serve & bounce), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(bounce), 2);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", int'(bounce), int'(e.kind));
        chk("pulse_score", int'(score), e.score);
        chk("pulse_lives", int'(lives), e.lives);
      end
    end
  end

  task automatic serve_seq(input int s, input int l);
    by2 = 12'd100;
    push(1'b0, s, l);
    for (int i = 0; i < 3; i++) frame();
    chk("serve_wait_state", int'(state), 1);
    frame();
    chk("play_state", int'(state), 2);
    chk("play_animate", int'(animate), 1);
    chk("play_endgame", int'(endgame), 0);
  endtask

  initial begin
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_lives", int'(lives), 2);
    chk("rst_score", int'(score), 0);
    chk("rst_endgame", int'(endgame), 1);
    chk("rst_animate", int'(animate), 0);
    chk("rst_serve", int'(serve), 0);
    rst_n = 1'b1;
    tick();
    tick();

    btn = 1'b1;
    tick();
    chk("start_state", int'(state), 1);
    chk("start_endgame", int'(endgame), 0);
    chk("start_lives", int'(lives), 2);
    chk("start_score", int'(score), 0);
    serve_seq(0, 2);

    by2 = 12'd476;
    push(1'b1, 1, 2);
    frame();
    chk("hit1_score", int'(score), 1);
    for (int i = 0; i < 3; i++) frame();
    chk("lock_score", int'(score), 1);
    by2 = 12'd400;
    frame();
    by2 = 12'd476;
    push(1'b1, 2, 2);
    frame();
    chk("hit2_score", int'(score), 2);

    bx1 = 12'd10;
    bx2 = 12'd20;
    by2 = 12'd479;
    frame();
    chk("miss1_state", int'(state), 3);
    chk("miss1_lives", int'(lives), 1);
    chk("miss1_endgame", int'(endgame), 1);
    frame();
    chk("miss1_next", int'(state), 1);
    bx1 = 12'd300;
    bx2 = 12'd310;
    serve_seq(2, 1);

    by2 = 12'd479;
    push(1'b1, 3, 1);
    frame();
    chk("edge_state", int'(state), 2);
    chk("edge_lives", int'(lives), 1);
    chk("edge_score", int'(score), 3);
    by2 = 12'd100;
    frame();

    bx1 = 12'd10;
    bx2 = 12'd20;
    by2 = 12'd479;
    frame();
    chk("miss2_state", int'(state), 3);
    chk("miss2_lives", int'(lives), 0);
    frame();
    chk("over_state", int'(state), 4);
    for (int i = 0; i < 5; i++) frame();
    chk("over_hold", int'(state), 4);
    chk("over_endgame", int'(endgame), 1);
    chk("over_score", int'(score), 3);
    frame();
    chk("idle_state", int'(state), 0);
    chk("idle_score", int'(score), 3);
    tick();
    tick();
    chk("held_btn_idle", int'(state), 0);
    btn = 1'b0;
    tick();
    btn = 1'b1;
    tick();
    chk("restart_state", int'(state), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_lives", int'(lives), 2);
    bx1 = 12'd300;
    bx2 = 12'd310;
    serve_seq(0, 2);

    for (int i = 1; i <= 1026; i++) begin
      by2 = 12'd100;
      frame();
      by2 = 12'd476;
      push(1'b1, (i > 1023) ? 1023 : i, 2);
      frame();
    end
    chk("sat_score", int'(score), 1023);
    chk("sat_state", int'(state), 2);

    by2 = 12'd100;
    frame();
    by2 = 12'd476;
    stb = 1'b1;
    tick();
    stb = 1'b0;
    chk("pre_rst_bounce", int'(bounce), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_lives", int'(lives), 2);
    chk("arst_endgame", int'(endgame), 1);
    chk("arst_animate", int'(animate), 0);
    chk("arst_bounce", int'(bounce), 0);
    chk("arst_serve", int'(serve), 0);
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level game sequencer for the Pong datapath.
- Generates the endgame and animate controls consumed by the paddle and ball blocks.
- Detects paddle/ball contact and bottom-edge misses from the edge coordinates those blocks publish, and issues serve and bounce pulses to the ball.
- Tracks score and remaining lives; sits between the paddle/ball objects and the VGA/score display logic.

Parameters:
- LIVES, 3, lives loaded at game start (1..15)
- SERVE_FRAMES, 60, animation strobes spent in SERVE before the ball launches (>=1)
- OVER_FRAMES, 120, animation strobes spent in OVER before returning to IDLE (>=1)
- SCORE_W, 10, score counter width
- D_HEIGHT, 480, display height; the miss line is D_HEIGHT-1

Ports:
- i_clk  in  1  base clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ani_stb  in  1  animation strobe, one i_clk cycle per frame
- i_btn_active  in  1  any paddle button pressed (level)
- i_ball_x1, i_ball_x2, i_ball_y2  in  12 each  ball left, right and bottom edges
- i_pad_x1, i_pad_x2, i_pad_y1  in  12 each  paddle left, right and top edges
- o_endgame  out  1  level; holds paddle/ball at start position
- o_animate  out  1  level; enables object motion
- o_serve  out  1  one-cycle pulse; launch ball
- o_bounce  out  1  one-cycle pulse; ball reverses vertical direction
- o_score  out  SCORE_W  hits this game
- o_lives  out  4  lives remaining
- o_state  out  3  current state encoding, for debug/display

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, timer=0, hit_lock=0, btn_q=0
  - o_score=0, o_lives=LIVES, o_serve=0, o_bounce=0
- State encoding: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4. Unused codes return to IDLE on the next clock.
- Outputs per state:
  - o_endgame=1 in IDLE, MISS and OVER; 0 otherwise.
  - o_animate=1 only in PLAY.
  - Both are registered alongside the state.
- btn_q registers i_btn_active every cycle. A start event is i_btn_active & ~btn_q, so a button held from the previous game does not restart it.
- IDLE:
  - On a start event: load o_lives=LIVES, clear o_score, clear timer, go to SERVE.
- SERVE:
  - timer increments on each i_ani_stb.
  - On the strobe where timer==SERVE_FRAMES-1: go to PLAY, pulse o_serve for that cycle, clear timer and hit_lock.
- PLAY (evaluated only on cycles with i_ani_stb=1; all comparisons unsigned 12-bit):
  - hit = (i_ball_y2>=i_pad_y1) & (i_ball_x2>=i_pad_x1) & (i_ball_x1<=i_pad_x2) & ~hit_lock.
  - On hit: pulse o_bounce one cycle, set hit_lock, increment o_score. The score saturates at 2^SCORE_W-1 and never wraps.
  - hit_lock clears on any strobe where i_ball_y2 < i_pad_y1.
  - miss = (i_ball_y2 >= D_HEIGHT-1) & ~hit.
  - On miss: decrement o_lives (saturating at 0), go to MISS.
  - Hit and miss conditions on the same strobe: hit wins and the state stays PLAY.
- MISS:
  - Lasts exactly one strobe, so the paddle recentres under o_endgame.
  - On the next i_ani_stb: go to OVER if o_lives==0, else go to SERVE with timer=0.
- OVER:
  - timer counts strobes; buttons are ignored.
  - On the strobe where timer==OVER_FRAMES-1: go to IDLE, clear timer.
  - o_score is held through OVER and IDLE until the next start event.
- Pulse rules:
  - o_serve and o_bounce are each high for exactly one i_clk cycle.
  - They never assert in the same cycle, and never outside PLAY entry or PLAY.
- Reset asserted mid-game forces the reset values immediately, with no pulse emitted.
- i_ani_stb low: no state change except IDLE→SERVE, which responds to start events on any cycle.

Test Plan:
(SERVE_FRAMES=4, OVER_FRAMES=6, LIVES=2, strobe every 4 clocks)
- Reset, then press the button: o_endgame drops, state=SERVE, o_lives=2, o_score=0. The 4th strobe later gives an o_serve single-cycle pulse, state=PLAY, o_animate=1.
- In PLAY, ball x1/x2=300/310, pad x1/x2=290/350, ball y2 rising past pad y1=475: exactly one o_bounce and o_score=1. Hold overlap for 3 more strobes: no further bounces until y2<475, then re-entry gives o_score=2.
- Ball y2=479 with x outside the paddle: state MISS, o_lives=1, o_endgame=1 for one strobe, then SERVE.
- Second miss: o_lives=0, MISS then OVER. o_endgame stays 1 for 6 strobes while the button is held, then IDLE. Restart requires release and re-press. o_score is held through OVER.
- Same strobe with ball y2=479 overlapping the paddle: bounce, no miss, o_lives unchanged.
- Drive o_score toward 1023 (SCORE_W=10) via repeated hits: it stays 1023. Assert i_rst_n=0 mid-PLAY: all outputs return to reset values asynchronously.
